// File: rtl/if_fetch_buffer.sv
// Instruction fetch front end: issues credit-limited icache requests, tags each
// one with its PC, queues returned instructions for ID and discards stale returns.
module if_fetch_buffer #(
    parameter int          IWIDTH = 14,
    parameter int          QDEPTH = 4,
    parameter logic [31:0] NOP    = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pc_start,
    input  logic [29:0]             start_adr,
    input  logic                    redirect,
    input  logic [29:0]             redirect_adr,
    output logic                    ic_req_valid,
    output logic [IWIDTH-1:0]       ic_req_adr,
    input  logic                    ic_req_ready,
    input  logic                    ic_rsp_valid,
    input  logic [31:0]             ic_rsp_data,
    input  logic                    id_stall,
    output logic [31:0]             inst_id,
    output logic [29:0]             pc_id,
    output logic                    id_valid,
    output logic [29:0]             pc_if,
    output logic [$clog2(QDEPTH):0] fq_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_ONE   = 1;
    localparam logic [PW-1:0] P_ONE   = 1;
    localparam logic [CW:0]   C_LIMIT = QDEPTH;

    logic            r_run;
    logic [29:0]     r_pc_if;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_fq_count;
    logic [PW-1:0]   r_tag_wr, r_tag_rd;
    logic [PW-1:0]   r_q_wr, r_q_rd;
    logic [29:0]     r_tag_mem [QDEPTH];
    logic [61:0]     r_q_mem   [QDEPTH];

    logic            w_flush;
    logic [CW:0]     w_credit_used;
    logic            w_req_valid;
    logic            w_hs;
    logic            w_rsp;
    logic            w_dropping;
    logic            w_accept;
    logic            w_tag_pop;
    logic            w_pop;
    logic [CW-1:0]   w_out_after_rsp;
    logic [61:0]     w_head;

    assign w_flush       = pc_start | redirect;
    // Queued plus in-flight instructions never exceed the queue size, so a push
    // always finds room.
    assign w_credit_used = {1'b0, r_fq_count} + {1'b0, r_outstanding};
    assign w_req_valid   = r_run & ~w_flush & (w_credit_used < C_LIMIT);
    assign w_hs          = w_req_valid & ic_req_ready;
    // A response with nothing outstanding is spurious and ignored entirely.
    assign w_rsp         = ic_rsp_valid & (r_outstanding != '0);
    assign w_dropping    = (r_drop_cnt != '0);
    assign w_accept      = w_rsp & ~w_dropping & ~w_flush;
    assign w_tag_pop     = w_rsp & ~w_dropping;
    assign w_pop         = id_valid & ~id_stall;
    assign w_out_after_rsp = r_outstanding - (w_rsp ? C_ONE : '0);

    assign w_head        = r_q_mem[r_q_rd];
    assign id_valid      = (r_fq_count != '0);
    assign inst_id       = id_valid ? w_head[31:0]  : NOP;
    assign pc_id         = id_valid ? w_head[61:32] : 30'd0;
    assign ic_req_valid  = w_req_valid;
    assign ic_req_adr    = r_pc_if[IWIDTH-1:0];
    assign pc_if         = r_pc_if;
    assign fq_count      = r_fq_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_pc_if       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_fq_count    <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_q_wr        <= '0;
            r_q_rd        <= '0;
        end else begin
            if (pc_start)
                r_run <= 1'b1;

            if (pc_start)
                r_pc_if <= start_adr;
            else if (redirect)
                r_pc_if <= redirect_adr;
            else if (w_hs)
                r_pc_if <= r_pc_if + 30'd1;

            if (w_hs && !w_rsp)
                r_outstanding <= r_outstanding + C_ONE;
            else if (!w_hs && w_rsp)
                r_outstanding <= r_outstanding - C_ONE;

            // Everything still in flight after a flush belongs to the old stream.
            if (w_flush)
                r_drop_cnt <= w_out_after_rsp;
            else if (w_rsp && w_dropping)
                r_drop_cnt <= r_drop_cnt - C_ONE;

            if (w_flush) begin
                r_tag_wr <= '0;
                r_tag_rd <= '0;
            end else begin
                if (w_hs)
                    r_tag_wr <= r_tag_wr + P_ONE;
                if (w_tag_pop)
                    r_tag_rd <= r_tag_rd + P_ONE;
            end

            if (w_flush) begin
                r_q_wr     <= '0;
                r_q_rd     <= '0;
                r_fq_count <= '0;
            end else begin
                if (w_accept)
                    r_q_wr <= r_q_wr + P_ONE;
                if (w_pop)
                    r_q_rd <= r_q_rd + P_ONE;
                if (w_accept && !w_pop)
                    r_fq_count <= r_fq_count + C_ONE;
                else if (!w_accept && w_pop)
                    r_fq_count <= r_fq_count - C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs)
            r_tag_mem[r_tag_wr] <= r_pc_if;
        if (w_accept)
            r_q_mem[r_q_wr] <= {r_tag_mem[r_tag_rd], ic_rsp_data};
    end

endmodule
